// File: rtl/l1_cache_pkg.sv
// Shared definitions for the L1 data cache: FSM state encoding, geometry and address slicing.
package l1_cache_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE        = 3'd0;
  localparam state_t COMPARE     = 3'd1;
  localparam state_t WRITEBACK   = 3'd2;
  localparam state_t ALLOCATE    = 3'd3;
  localparam state_t REFILL_DONE = 3'd4;

  function automatic int num_sets(input int cache_size, input int block_size, input int num_ways);
    return cache_size / block_size / num_ways;
  endfunction

  function automatic int off_width(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int idx_width(input int cache_size, input int block_size, input int num_ways);
    return $clog2(num_sets(cache_size, block_size, num_ways));
  endfunction

  function automatic int tag_width(input int addr_width, input int cache_size,
                                   input int block_size, input int num_ways);
    return addr_width - idx_width(cache_size, block_size, num_ways) - off_width(block_size);
  endfunction

  // Extracts 'width' bits starting at 'lsb'; callers narrow the result to the field width.
  function automatic int unsigned addr_field(input int unsigned addr, input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/l1_cache_lru.sv
// Per-set LRU age tracking: ages form a permutation per set, 0 = most recently used.
module l1_lru #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4,
  parameter int IDX_W    = 2,
  parameter int WAY_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    set_idx,
  input  logic                access,
  input  logic [WAY_W-1:0]    way,
  input  logic [NUM_WAYS-1:0] valid_row,
  output logic [WAY_W-1:0]    victim
);

  logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] old_age;
  logic             found;

  assign old_age = age[set_idx][way];

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else if (access) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < old_age)
          age[set_idx][w] <= age[set_idx][w] + WAY_W'(1);
      end
    end
  end

  // NOTE: every variable gets a default before any conditional path, so no latch is inferred.
  always_comb begin
    victim = WAY_W'(NUM_WAYS - 1);
    found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_row[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && age[set_idx][w] == WAY_W'(NUM_WAYS - 1))
        victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/l1_cache.sv
// Set-associative write-back, write-allocate L1 data cache with LRU replacement.
// Define L1_STATS_EN to add saturating hit/miss/L2-hit counters (hit_count, miss_count, l2_hit_count).
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int CACHE_SIZE = 256,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 cpu_addr,
  input  logic [DATA_WIDTH-1:0]                 cpu_data_in,
  input  logic                                  cpu_read,
  input  logic                                  cpu_write,
  output logic [DATA_WIDTH-1:0]                 cpu_data_out,
  output logic                                  cpu_ready,
  output logic                                  l1_hit,
  output logic [ADDR_WIDTH-1:0]                 l2_cache_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_out,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_in,
  output logic                                  l2_cache_read,
  output logic                                  l2_cache_write,
  input  logic                                  l2_cache_ready,
  input  logic                                  l2_cache_hit
);

  localparam int NUM_SETS = num_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int OFF_W    = off_width(BLOCK_SIZE);
  localparam int IDX_W    = idx_width(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int TAG_W    = tag_width(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int WAY_W    = $clog2(NUM_WAYS);

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_data;
  logic                   req_write;
  logic [WAY_W-1:0]       victim_way;

  logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]    dirty_q [NUM_SETS];
  logic [TAG_W-1:0]       tag_mem [NUM_SETS][NUM_WAYS];
  block_t                 data_mem [NUM_SETS][NUM_WAYS];

  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       req_idx;
  logic [OFF_W-1:0]       req_off;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic [WAY_W-1:0]       lru_victim;
  logic                   complete;
  logic [WAY_W-1:0]       access_way;

  assign req_off = OFF_W'(addr_field(32'(req_addr), 0, OFF_W));
  assign req_idx = IDX_W'(addr_field(32'(req_addr), OFF_W, IDX_W));
  assign req_tag = TAG_W'(addr_field(32'(req_addr), OFF_W + IDX_W, TAG_W));

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // A hit in COMPARE and the post-refill cycle are the two points where an access retires.
  assign complete   = (state == COMPARE && hit) || state == REFILL_DONE;
  assign access_way = (state == COMPARE) ? hit_way : victim_way;

  l1_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .IDX_W    (IDX_W),
    .WAY_W    (WAY_W)
  ) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_idx   (req_idx),
    .access    (complete),
    .way       (access_way),
    .valid_row (valid_q[req_idx]),
    .victim    (lru_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      req_addr          <= '0;
      req_data          <= '0;
      req_write         <= 1'b0;
      victim_way        <= '0;
      cpu_data_out      <= '0;
      cpu_ready         <= 1'b0;
      l1_hit            <= 1'b0;
      l2_cache_addr     <= '0;
      l2_cache_data_out <= '0;
      l2_cache_read     <= 1'b0;
      l2_cache_write    <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      cpu_ready <= 1'b0;
      l1_hit    <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_write || cpu_read) begin
            req_addr  <= cpu_addr;
            req_data  <= cpu_data_in;
            req_write <= cpu_write;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            l1_hit    <= 1'b1;
            if (req_write) dirty_q[req_idx][hit_way] <= 1'b1;
            else           cpu_data_out <= data_mem[req_idx][hit_way][req_off];
            state <= IDLE;
          end else begin
            victim_way <= lru_victim;
            if (valid_q[req_idx][lru_victim] && dirty_q[req_idx][lru_victim]) begin
              l2_cache_write    <= 1'b1;
              l2_cache_addr     <= {tag_mem[req_idx][lru_victim], req_idx, OFF_W'(0)};
              l2_cache_data_out <= data_mem[req_idx][lru_victim];
              state             <= WRITEBACK;
            end else begin
              l2_cache_read <= 1'b1;
              l2_cache_addr <= {req_tag, req_idx, OFF_W'(0)};
              state         <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (l2_cache_ready) begin
            l2_cache_write                <= 1'b0;
            dirty_q[req_idx][victim_way]  <= 1'b0;
            l2_cache_read                 <= 1'b1;
            l2_cache_addr                 <= {req_tag, req_idx, OFF_W'(0)};
            state                         <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (l2_cache_ready) begin
            l2_cache_read                <= 1'b0;
            valid_q[req_idx][victim_way] <= 1'b1;
            dirty_q[req_idx][victim_way] <= 1'b0;
            state                        <= REFILL_DONE;
          end
        end
        REFILL_DONE: begin
          cpu_ready <= 1'b1;
          if (req_write) dirty_q[req_idx][victim_way] <= 1'b1;
          else           cpu_data_out <= data_mem[req_idx][victim_way][req_off];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data storage carry no reset; the valid bits alone decide whether contents are used.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && l2_cache_ready) begin
      tag_mem[req_idx][victim_way]  <= req_tag;
      data_mem[req_idx][victim_way] <= l2_cache_data_in;
    end else if (complete && req_write) begin
      data_mem[req_idx][access_way][req_off] <= req_data;
    end
  end

`ifdef L1_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] l2_hit_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count    <= '0;
      miss_count   <= '0;
      l2_hit_count <= '0;
    end else begin
      if (state == COMPARE && hit && hit_count != '1)
        hit_count <= hit_count + 16'd1;
      if (state == COMPARE && !hit && miss_count != '1)
        miss_count <= miss_count + 16'd1;
      if (state == ALLOCATE && l2_cache_ready && l2_cache_hit && l2_hit_count != '1)
        l2_hit_count <= l2_hit_count + 16'd1;
    end
  end
`else
  logic unused_l2_hit;
  assign unused_l2_hit = l2_cache_hit;
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed scenarios plus random accesses against a recency-list model.
module tb_l1_cache;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int BS = 16;
  localparam int NW = 4;
  localparam int NS = 4;

  typedef logic [BS-1:0][DW-1:0] block_t;
  typedef struct packed { logic wr; logic [AW-1:0] addr; block_t data; } txn_t;
  typedef struct packed { logic [4:0] tag; logic dirty; block_t data; } line_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic          cpu_read;
  logic          cpu_write;
  logic [DW-1:0] cpu_data_out;
  logic          cpu_ready;
  logic          l1_hit;
  logic [AW-1:0] l2_cache_addr;
  block_t        l2_cache_data_out;
  block_t        l2_cache_data_in;
  logic          l2_cache_read;
  logic          l2_cache_write;
  logic          l2_cache_ready;
  logic          l2_cache_hit;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cpu_addr          (cpu_addr),
    .cpu_data_in       (cpu_data_in),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_data_out      (cpu_data_out),
    .cpu_ready         (cpu_ready),
    .l1_hit            (l1_hit),
    .l2_cache_addr     (l2_cache_addr),
    .l2_cache_data_out (l2_cache_data_out),
    .l2_cache_data_in  (l2_cache_data_in),
    .l2_cache_read     (l2_cache_read),
    .l2_cache_write    (l2_cache_write),
    .l2_cache_ready    (l2_cache_ready),
    .l2_cache_hit      (l2_cache_hit)
  );

  int   tests = 0;
  int   fails = 0;
  int   excl_err = 0;
  txn_t l2_log[$];
  txn_t exp_log[$];
  line_t model_sets[NS][$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk_txn(input logic wr, input logic [AW-1:0] addr, input block_t data);
    txn_t t;
    t.wr   = wr;
    t.addr = addr;
    t.data = data;
    return t;
  endfunction

  function automatic block_t fill_block(input logic [AW-1:0] block_addr);
    block_t b;
    for (int k = 0; k < BS; k++) b[k] = block_addr[7:0] + 8'(k);
    return b;
  endfunction

  // L2 responder: ready pulses 3 cycles after a request is seen; every transaction is logged.
  initial begin : l2_model
    int cnt;
    cnt = 0;
    l2_cache_ready   = 1'b0;
    l2_cache_hit     = 1'b0;
    l2_cache_data_in = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        l2_cache_ready = 1'b0;
      end else if (l2_cache_ready) begin
        l2_cache_ready = 1'b0;
        cnt = 0;
      end else if (l2_cache_read || l2_cache_write) begin
        if (l2_cache_read && l2_cache_write) excl_err++;
        cnt++;
        if (cnt == 3) begin
          l2_cache_data_in = fill_block(l2_cache_addr);
          l2_cache_hit     = 1'($urandom_range(0, 1));
          l2_cache_ready   = 1'b1;
          l2_log.push_back(mk_txn(l2_cache_write, l2_cache_addr,
                                  l2_cache_write ? l2_cache_data_out : l2_cache_data_in));
        end
      end
    end
  end

  task automatic model_reset();
    for (int s = 0; s < NS; s++) model_sets[s].delete();
  endtask

  // Each set is a recency list, most recent first; a full set evicts its least recent block.
  task automatic model_access(input logic wr, input logic [AW-1:0] addr, input logic [7:0] wdata,
                              output logic hit, output logic [7:0] rdata);
    logic [4:0] tag;
    int         idx;
    int         off;
    int         pos;
    line_t      ln;
    line_t      v;
    tag = addr[10:6];
    idx = int'(addr[5:4]);
    off = int'(addr[3:0]);
    pos = -1;
    exp_log.delete();
    for (int i = 0; i < model_sets[idx].size(); i++)
      if (model_sets[idx][i].tag == tag) pos = i;
    hit = (pos >= 0);
    if (hit) begin
      ln = model_sets[idx][pos];
      model_sets[idx].delete(pos);
    end else begin
      if (model_sets[idx].size() == NW) begin
        v = model_sets[idx].pop_back();
        if (v.dirty) exp_log.push_back(mk_txn(1'b1, {v.tag, addr[5:4], 4'h0}, v.data));
      end
      ln.tag   = tag;
      ln.dirty = 1'b0;
      ln.data  = fill_block({tag, addr[5:4], 4'h0});
      exp_log.push_back(mk_txn(1'b0, {tag, addr[5:4], 4'h0}, ln.data));
    end
    rdata = ln.data[off];
    if (wr) begin
      ln.data[off] = wdata;
      ln.dirty     = 1'b1;
    end
    model_sets[idx].push_front(ln);
  endtask

  task automatic do_access(input logic wr, input logic [AW-1:0] addr, input logic [7:0] wdata);
    logic       exp_hit;
    logic [7:0] exp_data;
    logic       got;
    int         cycles;
    model_access(wr, addr, wdata, exp_hit, exp_data);
    l2_log.delete();
    cpu_addr    = addr;
    cpu_data_in = wdata;
    cpu_write   = wr;
    cpu_read    = !wr;
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (cpu_ready) got = 1'b1;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    check("ready_seen", got, 1'b1);
    if (got) begin
      check("l1_hit", l1_hit, exp_hit);
      if (!wr) check("read_data", cpu_data_out, exp_data);
      if (exp_hit) check("hit_latency", cycles, 2);
      check("l2_txn_count", l2_log.size(), exp_log.size());
      for (int i = 0; i < l2_log.size() && i < exp_log.size(); i++) begin
        check("l2_txn_kind", l2_log[i].wr, exp_log[i].wr);
        check("l2_txn_addr", l2_log[i].addr, exp_log[i].addr);
        check("l2_txn_data", l2_log[i].data, exp_log[i].data);
      end
      @(negedge clk);
      check("ready_pulse", cpu_ready, 1'b0);
    end
  endtask

  initial begin : main
    logic          got;
    int            n;
    logic [AW-1:0] a;
    rst_n       = 1'b0;
    cpu_addr    = '0;
    cpu_data_in = '0;
    cpu_read    = 1'b0;
    cpu_write   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_l1_hit", l1_hit, 1'b0);
    check("rst_data_out", cpu_data_out, 8'h00);
    check("rst_l2_read", l2_cache_read, 1'b0);
    check("rst_l2_write", l2_cache_write, 1'b0);
    check("rst_l2_addr", l2_cache_addr, 11'h000);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    do_access(1'b0, 11'h001, 8'h00);
    check("first_read_data", cpu_data_out, 8'h01);
    do_access(1'b0, 11'h000, 8'h00);
    do_access(1'b0, 11'h002, 8'h00);
    do_access(1'b0, 11'h005, 8'h00);
    check("hit_read_data", cpu_data_out, 8'h05);
    do_access(1'b0, 11'h010, 8'h00);
    do_access(1'b0, 11'h014, 8'h00);
    do_access(1'b0, 11'h01A, 8'h00);
    check("set1_hit_data", cpu_data_out, 8'h1A);
    do_access(1'b0, 11'h101, 8'h00);
    do_access(1'b0, 11'h000, 8'h00);

    do_access(1'b1, 11'h003, 8'hA5);
    do_access(1'b0, 11'h040, 8'h00);
    do_access(1'b0, 11'h080, 8'h00);
    do_access(1'b0, 11'h0C0, 8'h00);
    do_access(1'b0, 11'h140, 8'h00);
    if (l2_log.size() != 0) begin
      check("wb_is_write", l2_log[0].wr, 1'b1);
      check("wb_addr", l2_log[0].addr, 11'h000);
      check("wb_byte3", l2_log[0].data[3], 8'hA5);
    end else begin
      check("wb_present", l2_log.size(), 2);
    end

    cpu_addr = 11'h001;
    cpu_read = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (l2_cache_read) got = 1'b1;
    end
    check("alloc_reached", got, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_l2_read", l2_cache_read, 1'b0);
    check("abort_l2_write", l2_cache_write, 1'b0);
    check("abort_cpu_ready", cpu_ready, 1'b0);
    cpu_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_access(1'b0, 11'h001, 8'h00);

    for (int i = 0; i < 400; i++) begin
      a = {5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      do_access(1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    check("l2_exclusive", excl_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
